// File: rtl/spi_slave_frame.sv
// SPI slave: DATA_W-bit MSB-first words in any CPOL/CPHA mode, full-duplex, with per-frame word accounting.
// rx_valid rises 1 clk after the final synchronised sample edge; a word completing while rx_valid && !rx_ready is dropped and sets overrun.
module spi_slave_frame #(
  parameter int DATA_W      = 8,
  parameter int FRAME_WORDS = 4,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2,
  localparam int IDX_W      = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sck,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_req,
  output logic [DATA_W-1:0] rx_data,
  output logic [IDX_W-1:0]  rx_idx,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              frame_done,
  output logic              frame_ok
);
  localparam int BIT_W = $clog2(DATA_W);
  localparam int CNT_W = $clog2(FRAME_WORDS + 2);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_OK   = CNT_W'(FRAME_WORDS);

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   s_sck, s_cs, s_mosi;
  logic                   sck_prev, cs_prev, in_frame;
  logic                   sck_rise, sck_fall, sample_edge, shift_edge, cs_fall, word_end;
  logic [BIT_W-1:0]       bit_cnt;
  logic [CNT_W-1:0]       word_cnt;
  logic [IDX_W-1:0]       idx_cnt;
  logic [DATA_W-2:0]      rx_shift;
  logic [DATA_W-2:0]      tx_rest;
  logic [DATA_W-1:0]      rx_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync  <= {SYNC_STAGES{CPOL}};
      cs_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign s_sck       = sck_sync[SYNC_STAGES-1];
  assign s_cs        = cs_sync[SYNC_STAGES-1];
  assign s_mosi      = mosi_sync[SYNC_STAGES-1];
  assign sck_rise    = s_sck & ~sck_prev;
  assign sck_fall    = ~s_sck & sck_prev;
  assign sample_edge = (CPOL == CPHA) ? sck_rise : sck_fall;
  assign shift_edge  = (CPOL == CPHA) ? sck_fall : sck_rise;
  assign cs_fall     = cs_prev & ~s_cs;
  assign rx_word     = {rx_shift, s_mosi};
  assign word_end    = in_frame & ~s_cs & sample_edge & (bit_cnt == LAST_BIT);
  // in_frame only sets on a seen cs fall, so a frame cut by reset stays ignored until cs cycles
  assign miso_oe     = in_frame & ~s_cs;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_prev   <= CPOL;
      cs_prev    <= 1'b0;
      in_frame   <= 1'b0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      idx_cnt    <= '0;
      rx_shift   <= '0;
      tx_rest    <= '0;
      miso       <= 1'b0;
      tx_req     <= 1'b0;
      rx_data    <= '0;
      rx_idx     <= '0;
      rx_valid   <= 1'b0;
      overrun    <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
    end else begin
      sck_prev   <= s_sck;
      cs_prev    <= s_cs;
      tx_req     <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;

      if (s_cs) begin
        in_frame <= 1'b0;
        bit_cnt  <= '0;
        word_cnt <= '0;
        idx_cnt  <= '0;
        rx_shift <= '0;
        if (in_frame) begin
          frame_done <= 1'b1;
          frame_ok   <= (word_cnt == CNT_OK) && (bit_cnt == '0);
        end
      end else if (cs_fall) begin
        in_frame <= 1'b1;
        if (!CPHA) begin
          miso    <= tx_data[DATA_W-1];
          tx_rest <= tx_data[DATA_W-2:0];
          tx_req  <= 1'b1;
        end
      end else if (in_frame) begin
        if (sample_edge) begin
          rx_shift <= rx_word[DATA_W-2:0];
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            if (word_cnt != CNT_SAT) word_cnt <= word_cnt + 1'b1;
            idx_cnt <= (idx_cnt == LAST_IDX) ? '0 : idx_cnt + 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        // A shift edge seen with bit_cnt at 0 starts a word: after a completed word (CPHA=0) or the first edge (CPHA=1)
        if (shift_edge) begin
          if (bit_cnt == '0) begin
            miso    <= tx_data[DATA_W-1];
            tx_rest <= tx_data[DATA_W-2:0];
            tx_req  <= 1'b1;
          end else begin
            miso    <= tx_rest[DATA_W-2];
            tx_rest <= {tx_rest[DATA_W-3:0], 1'b0};
          end
        end
      end

      if (word_end) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= rx_word;
          rx_idx   <= idx_cnt;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_frame.sv
// Bench for spi_slave_frame: instances 0..3 are modes 0..3 (8-bit, 4 words/frame), instance 4 is mode 0 with 12-bit words, 3 words/frame.
// Stimulus pushes expected words/frames into queues; a monitor pops on each rx handshake or frame_done.
module tb_spi_slave_frame;
  localparam int NI   = 5;
  localparam int HALF = 8;

  typedef struct { int inst; logic [11:0] data; int idx; } rx_exp_t;
  typedef struct { int inst; bit ok; } fr_exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [NI-1:0] cs_v, sck_v, miso_v, oe_v, txreq_v, rxv_v, ovr_v, fd_v, fok_v;
  logic          mosi, rx_ready;
  logic [11:0]   txd;
  logic [11:0]   rxd_v [NI];
  logic [1:0]    idx_v [NI];

  int vectors = 0;
  int miscompares = 0;
  rx_exp_t rx_q[$];
  fr_exp_t fr_q[$];
  logic [11:0] tx_src[$];
  bit rand_ready = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DW = (g == 4) ? 12 : 8;
    localparam int FW = (g == 4) ? 3 : 4;
    localparam bit CP = (g == 2) || (g == 3);
    localparam bit CH = (g == 1) || (g == 3);
    logic [DW-1:0] rx_data_l;
    spi_slave_frame #(.DATA_W(DW), .FRAME_WORDS(FW), .CPOL(CP), .CPHA(CH), .SYNC_STAGES(2)) u_dut (
      .clk(clk), .reset(reset), .sck(sck_v[g]), .cs(cs_v[g]), .mosi(mosi),
      .miso(miso_v[g]), .miso_oe(oe_v[g]), .tx_data(txd[DW-1:0]), .tx_req(txreq_v[g]),
      .rx_data(rx_data_l), .rx_idx(idx_v[g]), .rx_valid(rxv_v[g]), .rx_ready(rx_ready),
      .overrun(ovr_v[g]), .frame_done(fd_v[g]), .frame_ok(fok_v[g]));
    assign rxd_v[g] = 12'(rx_data_l);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every input change happens on a falling clk edge; tx_data is refreshed whenever a tx_req is seen.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (|txreq_v) begin
        if (tx_src.size() > 0) txd = tx_src.pop_front();
        else txd = 12'h000;
      end
      if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic frame_begin(input int inst, input logic [11:0] txw[$]);
    tx_src = txw;
    if (tx_src.size() > 0) txd = tx_src.pop_front();
    else txd = 12'h000;
    tick(HALF);
    cs_v[inst] = 1'b0;
    tick(HALF);
  endtask

  // Master side of one word (or nbits of it); cap collects miso at each sample edge.
  task automatic xfer(input int inst, input int dw, input logic [11:0] word, input int nbits,
                      output logic [11:0] cap);
    bit cp = (inst == 2) || (inst == 3);
    bit ch = (inst == 1) || (inst == 3);
    cap = 12'h000;
    for (int b = 0; b < nbits; b++) begin
      if (!ch) begin
        mosi = word[dw-1-b];
        tick(HALF);
        sck_v[inst] = ~cp;
        cap = {cap[10:0], miso_v[inst]};
        tick(HALF);
        sck_v[inst] = cp;
      end else begin
        sck_v[inst] = ~cp;
        mosi = word[dw-1-b];
        tick(HALF);
        sck_v[inst] = cp;
        cap = {cap[10:0], miso_v[inst]};
        tick(HALF);
      end
    end
  endtask

  task automatic frame_end(input int inst, input fr_exp_t f, input bit expect_done);
    tick(HALF);
    cs_v[inst] = 1'b1;
    if (expect_done) fr_q.push_back(f);
    tick(2 * HALF);
    check("miso_oe_idle", 32'(oe_v[inst]), 0);
  endtask

  task automatic run_frame(input int inst, input logic [11:0] rxw[$], input logic [11:0] txw[$],
                           input int tail_bits, input int deliver);
    int dw, fw;
    logic [11:0] cap;
    rx_exp_t e;
    fr_exp_t f;
    dw = (inst == 4) ? 12 : 8;
    fw = (inst == 4) ? 3 : 4;
    frame_begin(inst, txw);
    check("miso_oe_active", 32'(oe_v[inst]), 1);
    for (int w = 0; w < rxw.size(); w++) begin
      if (w < deliver) begin
        e.inst = inst; e.data = rxw[w]; e.idx = w % fw;
        rx_q.push_back(e);
      end
      xfer(inst, dw, rxw[w], dw, cap);
      if (w < txw.size()) check("miso_word", 32'(cap), 32'(txw[w]));
    end
    if (tail_bits > 0) xfer(inst, dw, 12'($urandom), tail_bits, cap);
    f.inst = inst;
    f.ok   = (rxw.size() == fw) && (tail_bits == 0);
    frame_end(inst, f, 1'b1);
  endtask

  task automatic rand_frame(input int inst, input int n);
    logic [11:0] rxw[$];
    logic [11:0] txw[$];
    logic [11:0] mask;
    mask = (inst == 4) ? 12'hFFF : 12'h0FF;
    for (int i = 0; i < n; i++) begin
      rxw.push_back(12'($urandom) & mask);
      txw.push_back(12'($urandom) & mask);
    end
    run_frame(inst, rxw, txw, 0, n);
  endtask

  // Monitor / scoreboard
  initial begin
    rx_exp_t e;
    fr_exp_t f;
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (rxv_v[i] && rx_ready) begin
          if (rx_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_rx: inst %0d delivered 0x%0h, expected nothing", i, rxd_v[i]);
          end else begin
            e = rx_q.pop_front();
            check("rx_inst", i, e.inst);
            check("rx_data", 32'(rxd_v[i]), 32'(e.data));
            check("rx_idx", 32'(idx_v[i]), e.idx);
          end
        end
        if (fd_v[i]) begin
          if (fr_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_frame_done: inst %0d, expected no frame_done", i);
          end else begin
            f = fr_q.pop_front();
            check("frame_inst", i, f.inst);
            check("frame_ok", 32'(fok_v[i]), 32'(f.ok));
          end
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] rxw[$];
    logic [11:0] txw[$];
    logic [11:0] cap;
    cs_v = '1; sck_v = 5'b01100; mosi = 1'b0; rx_ready = 1'b1; txd = 12'h000; reset = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < NI; i++)
      check("reset_outputs", {miso_v[i], oe_v[i], txreq_v[i], rxv_v[i], ovr_v[i], fd_v[i], fok_v[i], rxd_v[i], idx_v[i]}, 0);
    reset = 1'b0;
    tick(6);
    for (int i = 0; i < NI; i++)
      check("idle_after_reset", {oe_v[i], rxv_v[i], ovr_v[i], fd_v[i]}, 0);

    // Mode 0 directed frame
    rxw = '{12'hA5, 12'h3C, 12'hFF, 12'h00};
    txw = '{12'h5A, 12'hC3, 12'h0F, 12'hF0};
    run_frame(0, rxw, txw, 0, 4);
    check("overrun_clean", 32'(ovr_v[0]), 0);

    // Full duplex in every mode
    for (int m = 0; m < 4; m++) begin
      rxw = '{12'h12, 12'h34};
      txw = '{12'h96, 12'h69};
      run_frame(m, rxw, txw, 0, 2);
    end

    // Random traffic with random consumer stalls
    rand_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      rand_frame(m, 4);
      rand_frame(m, 1 + $urandom_range(0, 4));
    end
    rand_frame(4, 3);
    rand_ready = 1'b0;
    rx_ready = 1'b1;
    tick(4);

    // 12-bit words, index wraps modulo 3
    rxw = '{12'hABC, 12'h123, 12'hFFF, 12'h000, 12'h555};
    txw = '{12'h9A5, 12'h0F0, 12'hFFF, 12'h001, 12'h800};
    run_frame(4, rxw, txw, 0, 5);

    // Abort after 5 bits of the second word, then a clean frame restarts at index 0
    rxw = '{12'hC3};
    txw = '{12'h81};
    run_frame(0, rxw, txw, 5, 1);
    rand_frame(0, 4);
    check("overrun_after_abort", 32'(ovr_v[0]), 0);

    // Backpressure: only the first word lands, the rest overrun
    rx_ready = 1'b0;
    rxw = '{12'h11, 12'h22, 12'h33};
    txw = '{12'h44, 12'h55, 12'h66};
    run_frame(0, rxw, txw, 0, 1);
    check("bp_rx_valid", 32'(rxv_v[0]), 1);
    check("bp_rx_data", 32'(rxd_v[0]), 32'h11);
    check("bp_overrun", 32'(ovr_v[0]), 1);
    tick(1);
    rx_ready = 1'b1;
    tick(3);
    check("bp_drained", 32'(rxv_v[0]), 0);
    check("bp_overrun_sticky", 32'(ovr_v[0]), 1);

    // Reset mid-word, then a fresh frame
    txw = '{12'h33};
    frame_begin(0, txw);
    xfer(0, 8, 12'h0F0, 3, cap);
    reset = 1'b1;
    tick(1);
    check("reset_mid_word", {miso_v[0], oe_v[0], txreq_v[0], rxv_v[0], ovr_v[0], fd_v[0], fok_v[0], rxd_v[0], idx_v[0]}, 0);
    tick(2);
    reset = 1'b0;
    tick(6);
    check("oe_after_reset_cs_low", 32'(oe_v[0]), 0);
    frame_end(0, '{0, 1'b0}, 1'b0);
    rxw = '{12'h5A};
    txw = '{12'hB7};
    run_frame(0, rxw, txw, 0, 1);
    check("overrun_cleared", 32'(ovr_v[0]), 0);

    tick(8);
    check("rx_queue_empty", rx_q.size(), 0);
    check("frame_queue_empty", fr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
